shift_exe: RTL and testbench

//  Pipelined shift/rotate execution stage sitting directly upstream of, and wrapping, the bsi

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_exe_if.sv | 32 +++
 rtl/bsi.sv | 29 ++
 rtl/shift_exe.sv | 108 ++++++++++
 tb/tb_shift_exe.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift/rotate execution stage.
package shift_pkg;

  localparam int unsigned SHIFT_XLEN  = 32;
  localparam int unsigned SHIFT_TAG_W = 4;
  localparam int unsigned SHIFT_AMT_W = $clog2(SHIFT_XLEN);

  // Opcodes 5..7 are reserved and flagged as errors by the stage.
  typedef enum logic [2:0] {
    SHIFT_OP_SLL = 3'd0,
    SHIFT_OP_SRL = 3'd1,
    SHIFT_OP_SRA = 3'd2,
    SHIFT_OP_ROL = 3'd3,
    SHIFT_OP_ROR = 3'd4
  } shift_op_t;

  typedef struct packed {
    shift_op_t                op;
    logic [SHIFT_XLEN-1:0]    x;
    logic [SHIFT_AMT_W-1:0]   shamt;
    logic [SHIFT_TAG_W-1:0]   tag;
  } shift_cmd_t;

endpackage

// File: rtl/shift_exe_if.sv
// Command / response handshake bundle for shift_exe.
interface shift_exe_if #(
  parameter int unsigned W       = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned SHIFT_W = $clog2(W)
);

  logic               cmd_vld_i;
  logic               cmd_rdy_o;
  logic [2:0]         cmd_op_i;
  logic [W-1:0]       cmd_x_i;
  logic [SHIFT_W-1:0] cmd_shamt_i;
  logic [TAG_W-1:0]   cmd_tag_i;
  logic               rsp_vld_o;
  logic               rsp_rdy_i;
  logic [W-1:0]       rsp_y_o;
  logic [TAG_W-1:0]   rsp_tag_o;
  logic               rsp_err_o;

  // Producer of commands and consumer of responses.
  modport master (
    output cmd_vld_i, cmd_op_i, cmd_x_i, cmd_shamt_i, cmd_tag_i, rsp_rdy_i,
    input  cmd_rdy_o, rsp_vld_o, rsp_y_o, rsp_tag_o, rsp_err_o
  );

  // The execution stage itself.
  modport slave (
    input  cmd_vld_i, cmd_op_i, cmd_x_i, cmd_shamt_i, cmd_tag_i, rsp_rdy_i,
    output cmd_rdy_o, rsp_vld_o, rsp_y_o, rsp_tag_o, rsp_err_o
  );

endinterface

// File: rtl/bsi.sv
// Single-direction barrel shifter; direction and fill fixed at elaboration.
module bsi #(
  parameter int unsigned W       = 32,
  parameter int unsigned SHIFT_W = $clog2(W),
  parameter bit          P_RIGHT = 1'b0,
  parameter bit          P_ARITH = 1'b0
) (
  input  logic [W-1:0]       x,
  input  logic [SHIFT_W-1:0] s,
  output logic [W-1:0]       y
);

  // Log-depth shifter: stage i shifts by 2**i when s[i] is set.
  always_comb begin
    y = x;
    for (int i = 0; i < int'(SHIFT_W); i++) begin
      if (s[i]) begin
        if (P_RIGHT && P_ARITH) begin
          y = $unsigned($signed(y) >>> (1 << i));
        end else if (P_RIGHT) begin
          y = y >> (1 << i);
        end else begin
          y = y << (1 << i);
        end
      end
    end
  end

endmodule

// File: rtl/shift_exe.sv
// Two-stage shift/rotate execution stage: S1 holds the operands, S2 the result.
module shift_exe
  import shift_pkg::*;
#(
  parameter int unsigned W       = SHIFT_XLEN,
  parameter int unsigned SHIFT_W = $clog2(W),
  parameter int unsigned TAG_W   = SHIFT_TAG_W
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        kill_i,
  shift_exe_if.slave  bus
);

  // S1 storage uses the package command layout, so W/TAG_W track the package widths.
  logic               s1_vld_q;
  shift_cmd_t         s1_q;
  logic               s2_vld_q;
  logic [W-1:0]       s2_y_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic               s2_err_q;

  logic               s1_adv;
  logic               s2_adv;
  logic [SHIFT_W-1:0] rot_amt;
  logic [W-1:0]       sll_y, srl_y, sra_y, rl_y, rr_y;
  logic [W-1:0]       y_c;
  logic               err_c;

  // Stall chain; kill blocks both ports for the flush cycle.
  assign s2_adv        = !s2_vld_q || bus.rsp_rdy_i;
  assign s1_adv        = !s1_vld_q || s2_adv;
  assign bus.cmd_rdy_o = s1_adv && !kill_i;
  assign bus.rsp_vld_o = s2_vld_q && !kill_i;
  assign bus.rsp_y_o   = s2_y_q;
  assign bus.rsp_tag_o = s2_tag_q;
  assign bus.rsp_err_o = s2_err_q;

  // Complementary amount for the rotate halves; (W - s) mod W, so s=0 gives x unchanged.
  assign rot_amt = SHIFT_W'(W) - s1_q.shamt;

  bsi #(.W(W), .SHIFT_W(SHIFT_W), .P_RIGHT(1'b0), .P_ARITH(1'b0)) u_sll (.x(s1_q.x), .s(s1_q.shamt), .y(sll_y));
  bsi #(.W(W), .SHIFT_W(SHIFT_W), .P_RIGHT(1'b1), .P_ARITH(1'b0)) u_srl (.x(s1_q.x), .s(s1_q.shamt), .y(srl_y));
  bsi #(.W(W), .SHIFT_W(SHIFT_W), .P_RIGHT(1'b1), .P_ARITH(1'b1)) u_sra (.x(s1_q.x), .s(s1_q.shamt), .y(sra_y));
  bsi #(.W(W), .SHIFT_W(SHIFT_W), .P_RIGHT(1'b0), .P_ARITH(1'b0)) u_rl  (.x(s1_q.x), .s(rot_amt),     .y(rl_y));
  bsi #(.W(W), .SHIFT_W(SHIFT_W), .P_RIGHT(1'b1), .P_ARITH(1'b0)) u_rr  (.x(s1_q.x), .s(rot_amt),     .y(rr_y));

  // Opcode select; reserved opcodes produce zero with the error flag.
  always_comb begin
    y_c   = '0;
    err_c = 1'b0;
    case (s1_q.op)
      SHIFT_OP_SLL: y_c = sll_y;
      SHIFT_OP_SRL: y_c = srl_y;
      SHIFT_OP_SRA: y_c = sra_y;
      SHIFT_OP_ROL: y_c = sll_y | rr_y;
      SHIFT_OP_ROR: y_c = srl_y | rl_y;
      default:      err_c = 1'b1;
    endcase
  end

  // Pipeline registers; kill clears valids ahead of any handshake.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_vld_q <= 1'b0;
      s2_y_q   <= '0;
      s2_tag_q <= '0;
      s2_err_q <= 1'b0;
    end else if (kill_i) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= bus.cmd_vld_i;
        if (bus.cmd_vld_i) begin
          s1_q.op    <= shift_op_t'(bus.cmd_op_i);
          s1_q.x     <= bus.cmd_x_i;
          s1_q.shamt <= bus.cmd_shamt_i;
          s1_q.tag   <= bus.cmd_tag_i;
        end
      end
      if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_y_q   <= y_c;
          s2_tag_q <= s1_q.tag;
          s2_err_q <= err_c;
        end
      end
    end
  end

  // Response must be fully defined while offered.
  a_rsp_known: assert property (@(posedge clk_i) disable iff (arst_i)
    bus.rsp_vld_o |-> !$isunknown({bus.rsp_y_o, bus.rsp_tag_o, bus.rsp_err_o}));

  // Offered response holds until consumed.
  a_rsp_stable: assert property (@(posedge clk_i) disable iff (arst_i)
    (bus.rsp_vld_o && !bus.rsp_rdy_i) |=> (s2_vld_q && $stable({s2_y_q, s2_tag_q, s2_err_q})));

  // Reserved opcodes are legal but unusual.
  a_op_range: assert property (@(posedge clk_i) disable iff (arst_i)
    (bus.cmd_vld_i && bus.cmd_rdy_o) |-> (bus.cmd_op_i <= 3'd4))
    else $warning("shift_exe: reserved opcode %0d accepted", bus.cmd_op_i);

endmodule

// File: tb/tb_shift_exe.sv
// Directed bench for shift_exe.
module tb_shift_exe;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic arst;
  logic kill;
  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  shift_exe_if #(.W(32), .TAG_W(4)) bus ();

  shift_exe #(.W(32), .TAG_W(4)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .kill_i (kill),
    .bus    (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] x, input logic [4:0] s,
                       input logic [3:0] tag);
    bus.cmd_vld_i   = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_x_i     = x;
    bus.cmd_shamt_i = s;
    bus.cmd_tag_i   = tag;
  endtask

  // One command through an empty pipe with the consumer always ready.
  task automatic run1(input string name, input logic [2:0] op, input logic [31:0] x,
                      input logic [4:0] s, input logic [3:0] tag,
                      input logic [31:0] exp_y, input logic exp_err);
    bus.rsp_rdy_i = 1'b1;
    drive(op, x, s, tag);
    #1;
    chk1({name, ".rdy"}, bus.cmd_rdy_o, 1'b1);
    step();
    bus.cmd_vld_i = 1'b0;
    #1;
    chk1({name, ".vld_early"}, bus.rsp_vld_o, 1'b0);
    step();
    chk1({name, ".vld"}, bus.rsp_vld_o, 1'b1);
    chk32({name, ".y"}, bus.rsp_y_o, exp_y);
    chk32({name, ".tag"}, 32'(bus.rsp_tag_o), 32'(tag));
    chk1({name, ".err"}, bus.rsp_err_o, exp_err);
    step();
    chk1({name, ".vld_after"}, bus.rsp_vld_o, 1'b0);
  endtask

  initial begin
    arst            = 1'b1;
    kill            = 1'b0;
    bus.cmd_vld_i   = 1'b0;
    bus.cmd_op_i    = 3'd0;
    bus.cmd_x_i     = '0;
    bus.cmd_shamt_i = '0;
    bus.cmd_tag_i   = '0;
    bus.rsp_rdy_i   = 1'b0;

    // Reset state
    #12;
    chk1("rst.vld", bus.rsp_vld_o, 1'b0);
    chk32("rst.y", bus.rsp_y_o, 32'h0);
    chk32("rst.tag", 32'(bus.rsp_tag_o), 32'h0);
    chk1("rst.err", bus.rsp_err_o, 1'b0);
    arst = 1'b0;
    #1;
    chk1("rst.rdy", bus.cmd_rdy_o, 1'b1);
    step();

    // Single SRA with sign fill
    run1("sra", SHIFT_OP_SRA, 32'h8000_0010, 5'd4, 4'd3, 32'hF800_0001, 1'b0);

    // Back-to-back SLL, one per cycle
    bus.rsp_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(SHIFT_OP_SLL, 32'h1, 5'(i), 4'(i));
      #1;
      chk1("b2b.rdy", bus.cmd_rdy_o, 1'b1);
      step();
      if (i > 0) begin
        chk1("b2b.vld", bus.rsp_vld_o, 1'b1);
        chk32("b2b.y", bus.rsp_y_o, 32'h1 << (i - 1));
        chk32("b2b.tag", 32'(bus.rsp_tag_o), 32'(i - 1));
      end
    end
    bus.cmd_vld_i = 1'b0;
    step();
    chk1("b2b.vld_last", bus.rsp_vld_o, 1'b1);
    chk32("b2b.y_last", bus.rsp_y_o, 32'h80);
    chk32("b2b.tag_last", 32'(bus.rsp_tag_o), 32'h7);
    step();
    chk1("b2b.drained", bus.rsp_vld_o, 1'b0);

    // Rotates and boundary shift amounts
    run1("rol1", SHIFT_OP_ROL, 32'h8000_0001, 5'd1, 4'd1, 32'h0000_0003, 1'b0);
    run1("ror0", SHIFT_OP_ROR, 32'h1234_5678, 5'd0, 4'd2, 32'h1234_5678, 1'b0);
    run1("rol0", SHIFT_OP_ROL, 32'hCAFE_F00D, 5'd0, 4'd4, 32'hCAFE_F00D, 1'b0);
    run1("srl31", SHIFT_OP_SRL, 32'hFFFF_FFFF, 5'd31, 4'd5, 32'h0000_0001, 1'b0);
    run1("ror1", SHIFT_OP_ROR, 32'h0000_0001, 5'd1, 4'd6, 32'h8000_0000, 1'b0);
    run1("sll_ovf", SHIFT_OP_SLL, 32'h8000_0001, 5'd1, 4'd7, 32'h0000_0002, 1'b0);
    run1("sra_pos", SHIFT_OP_SRA, 32'h7000_0000, 5'd28, 4'd8, 32'h0000_0007, 1'b0);

    // Backpressure: 3 offered, 2 accepted, response held
    bus.rsp_rdy_i = 1'b0;
    drive(SHIFT_OP_SLL, 32'h3, 5'd4, 4'd10);
    #1;
    chk1("bp.rdy_a", bus.cmd_rdy_o, 1'b1);
    step();
    drive(SHIFT_OP_SRL, 32'hF0, 5'd4, 4'd11);
    #1;
    chk1("bp.rdy_b", bus.cmd_rdy_o, 1'b1);
    step();
    drive(SHIFT_OP_ROR, 32'hF, 5'd4, 4'd12);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp.rdy_stall", bus.cmd_rdy_o, 1'b0);
      chk1("bp.vld_hold", bus.rsp_vld_o, 1'b1);
      chk32("bp.y_hold", bus.rsp_y_o, 32'h30);
      chk32("bp.tag_hold", 32'(bus.rsp_tag_o), 32'd10);
      step();
    end
    bus.rsp_rdy_i = 1'b1;
    #1;
    chk1("bp.rdy_release", bus.cmd_rdy_o, 1'b1);
    step();
    bus.cmd_vld_i = 1'b0;
    chk32("bp.y_b", bus.rsp_y_o, 32'h0000_000F);
    chk32("bp.tag_b", 32'(bus.rsp_tag_o), 32'd11);
    step();
    chk1("bp.vld_c", bus.rsp_vld_o, 1'b1);
    chk32("bp.y_c", bus.rsp_y_o, 32'hF000_0000);
    chk32("bp.tag_c", 32'(bus.rsp_tag_o), 32'd12);
    step();
    chk1("bp.drained", bus.rsp_vld_o, 1'b0);

    // Kill with both stages full
    bus.rsp_rdy_i = 1'b0;
    drive(SHIFT_OP_SLL, 32'h1, 5'd1, 4'd1);
    step();
    drive(SHIFT_OP_SLL, 32'h1, 5'd2, 4'd2);
    step();
    chk1("kill.full", bus.rsp_vld_o, 1'b1);
    kill = 1'b1;
    drive(SHIFT_OP_SLL, 32'h1, 5'd3, 4'd3);
    #1;
    chk1("kill.rdy_mask", bus.cmd_rdy_o, 1'b0);
    chk1("kill.vld_mask", bus.rsp_vld_o, 1'b0);
    step();
    kill = 1'b0;
    bus.cmd_vld_i = 1'b0;
    bus.rsp_rdy_i = 1'b1;
    #1;
    chk1("kill.vld0", bus.rsp_vld_o, 1'b0);
    chk1("kill.rdy_back", bus.cmd_rdy_o, 1'b1);
    step();
    chk1("kill.vld1", bus.rsp_vld_o, 1'b0);
    step();
    chk1("kill.vld2", bus.rsp_vld_o, 1'b0);
    run1("post_kill", SHIFT_OP_SRL, 32'h8000_0000, 5'd31, 4'd9, 32'h0000_0001, 1'b0);

    // Reserved opcode
    run1("op7", 3'd7, 32'hDEAD_BEEF, 5'd3, 4'd5, 32'h0, 1'b1);
    run1("op5", 3'd5, 32'h1234_5678, 5'd1, 4'd13, 32'h0, 1'b1);

    // Asynchronous reset mid-stream
    bus.rsp_rdy_i = 1'b0;
    drive(SHIFT_OP_SLL, 32'h5, 5'd1, 4'd14);
    step();
    drive(SHIFT_OP_SLL, 32'h5, 5'd2, 4'd15);
    step();
    bus.cmd_vld_i = 1'b0;
    chk1("arst.pre", bus.rsp_vld_o, 1'b1);
    #2;
    arst = 1'b1;
    #1;
    chk1("arst.vld", bus.rsp_vld_o, 1'b0);
    chk32("arst.y", bus.rsp_y_o, 32'h0);
    chk32("arst.tag", 32'(bus.rsp_tag_o), 32'h0);
    #2;
    arst = 1'b0;
    bus.rsp_rdy_i = 1'b1;
    step();
    chk1("arst.stale0", bus.rsp_vld_o, 1'b0);
    step();
    chk1("arst.stale1", bus.rsp_vld_o, 1'b0);
    run1("post_rst", SHIFT_OP_ROL, 32'hF000_000F, 5'd4, 4'd3, 32'h0000_00FF, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
